wb_result_stage: RTL and testbench
==================================

# wb_result_stage

Result writeback stage for the 16-bit datapath. Takes completed ALU/shifter results, buffers them in a 2-entry skid buffer, and writes them into the register file through a ready-gated write port. On each retired write it updates `pipeline_out`, the feedback value selected by the A-operand mux, and the status flags. It is the consumer end of the operand path: the operand muxes feed the execute unit, and this block returns the results to storage and to the A-operand feedback path.

## Interface
Parameters:
- DATA_W, 16, result and register width
- REG_AW, 3, register-file address width (8 registers)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  in  1  execute stage presents a result this cycle
- in_ready  out  1  stage can accept a result this cycle
- in_data  in  DATA_W  result value
- in_dst  in  REG_AW  destination register index
- in_ovf  in  1  overflow flag computed by the execute unit
- rf_we  out  1  register-file write request (head entry valid)
- rf_waddr  out  REG_AW  write address (head entry dst)
- rf_wdata  out  DATA_W  write data (head entry data)
- rf_ready  in  1  register file accepts the write this cycle
- pipeline_out  out  DATA_W  last retired result, fed back to the A-operand mux
- status  out  3  {Z, N, V} of the last retired result
- busy  out  1  buffer non-empty

## Operation
- Accept: an entry is accepted when in_valid && in_ready. The entry is {in_data, in_dst, in_ovf}.
- Retire: the head entry retires when rf_we && rf_ready.
- Buffer: 2-entry FIFO. The occupancy FSM has three states:
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without retire.
  - ONE -> EMPTY on retire without accept.
  - ONE -> ONE on simultaneous accept and retire. The new entry becomes head in the next cycle.
  - TWO -> ONE on retire. No accept is possible in TWO.
- Outputs derived from state:
  - in_ready = (state != TWO). It depends on state only, never on rf_ready, so there is no combinational in->out path.
  - rf_we = busy = (state != EMPTY).
  - rf_waddr and rf_wdata are driven from the registered head entry.
- On retire, registered in the same edge:
  - pipeline_out <= head data.
  - status <= {head data == 0, head data[15], head ovf}.
- Flags:
  - Z is the full 16-bit compare.
  - N is the MSB.
  - V is passed through from in_ovf unmodified. No flag is computed on accept.
- Holding rules:
  - While rf_ready = 0, the head, rf_waddr, rf_wdata and rf_we hold stable.
  - pipeline_out and status hold their last retired values indefinitely.
- Register index: destination 0 is an ordinary writable register. No special casing.
- Reset, mid-operation included: both buffered entries are discarded without being written. state = EMPTY. Outputs after reset:
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - pipeline_out = 0, status = 3'b000
  - in_ready = 1, busy = 0
- Input handshake rule: in_valid may be dropped freely. Inputs presented while in_ready = 0 are ignored, not queued.

## Timing
- Fill latency: a result accepted at edge t, with the buffer EMPTY, drives rf_we/rf_wdata during cycle t+1.
- Retire latency: if rf_ready = 1 in cycle t+1, pipeline_out and status show that result from cycle t+2.
- Throughput: one result per cycle sustained while rf_ready is held 1 (the FSM stays in ONE).
- Backpressure: with rf_ready = 0, in_ready falls the cycle after the second accept. The first rf_ready = 1 re-raises in_ready on the following cycle.
- Ordering: writes strictly preserve acceptance order.

## Structure
- Shared package wb_pkg holds:
  - DATA_W, REG_AW
  - the state encoding (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2)
  - status bit indices STAT_Z = 2, STAT_N = 1, STAT_V = 0
- Sub-module wb_skid_fifo: 2-entry storage plus occupancy FSM, exposing push/pop/head/full/empty.
- The top level adds the flag logic and the pipeline_out/status registers.

## Test plan
- Reset, then hold in_valid = 0 -> rf_we = 0, pipeline_out = 0, status = 000, in_ready = 1 for 10 cycles.
- Single write: in_data = 16'h8000, dst = 5, ovf = 0, rf_ready = 1.
  - Expect rf_we = 1, waddr = 5, wdata = 8000 one cycle later.
  - One cycle after that, pipeline_out = 8000 and status = 010.
- Streaming: results 1, 2, 3, 4 on consecutive cycles with rf_ready = 1 -> four consecutive writes in order, in_ready held 1 throughout, final pipeline_out = 4.
- Backpressure: rf_ready = 0 while pushing 16'h0000 (ovf = 1), then 16'h0007.
  - in_ready drops after the second accept and a third input is ignored.
  - Raise rf_ready: writes occur 0000 then 0007; status passes through 101, then ends at 000.
- Reset mid-operation: assert reset with TWO entries buffered -> no writes issued, all outputs return to reset values on the next cycle.
- Simultaneous accept and retire in ONE -> state stays ONE, and the new entry appears on rf_wdata the following cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, occupancy encoding and status-bit positions for the
// result writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  localparam int unsigned STAT_Z = 2;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_V = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry skid buffer: head/tail registers plus an occupancy FSM.
// Pushes while full and pops while empty are ignored.
module wb_skid_fifo #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_entry,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  import wb_pkg::*;

  occ_state_t state_q, state_d;
  logic [W-1:0] head_q, tail_q;
  logic do_push, do_pop;

  assign do_push = push && (state_q != TWO);
  assign do_pop  = pop && (state_q != EMPTY);
  assign head    = head_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (do_push) state_d = ONE;
      ONE: begin
        if (do_push && !do_pop)      state_d = TWO;
        else if (!do_push && do_pop) state_d = EMPTY;
      end
      TWO:     if (do_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    full  = (state_q == TWO);
    empty = (state_q == EMPTY);
  end

  // Head always holds the oldest entry; in ONE a simultaneous push/pop
  // replaces the head directly, otherwise the new entry parks in the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (do_push) head_q <= push_entry;
        ONE: begin
          if (do_push && do_pop) head_q <= push_entry;
          else if (do_push)      tail_q <= push_entry;
        end
        TWO:     if (do_pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_result_stage.sv
// Result writeback stage: buffers execute results and retires them to the
// register file, updating the A-operand feedback value and {Z,N,V} flags.
module wb_result_stage #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned REG_AW = wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_ovf,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic [DATA_W-1:0] pipeline_out,
  output logic [2:0]        status,
  output logic              busy
);
  import wb_pkg::*;

  localparam int unsigned EW = DATA_W + REG_AW + 1;

  logic [EW-1:0] in_entry, head;
  logic          push, pop, full, empty;
  logic          head_ovf;

  assign in_entry = {in_data, in_dst, in_ovf};

  wb_skid_fifo #(.W(EW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (in_entry),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // in_ready comes from state only, keeping rf_ready off any path to in_ready.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && rf_ready;
  assign rf_we    = !empty;
  assign busy     = !empty;

  assign rf_wdata = head[EW-1 -: DATA_W];
  assign rf_waddr = head[REG_AW:1];
  assign head_ovf = head[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipeline_out <= '0;
      status       <= '0;
    end else if (pop) begin
      pipeline_out   <= rf_wdata;
      status[STAT_Z] <= (rf_wdata == '0);
      status[STAT_N] <= rf_wdata[DATA_W-1];
      status[STAT_V] <= head_ovf;
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// Self-checking bench for wb_result_stage: driver pushes expected writes into
// a queue, a negedge monitor pops and compares on every modelled retire.
module tb_wb_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_dst;
  logic        in_ovf;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [15:0] pipeline_out;
  logic [2:0]  status;
  logic        busy;

  always #5 clk = ~clk;

  wb_result_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dst       (in_dst),
    .in_ovf       (in_ovf),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_ready     (rf_ready),
    .pipeline_out (pipeline_out),
    .status       (status),
    .busy         (busy)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dst;
    logic        ovf;
  } ent_t;

  ent_t        exp_q[$];
  int          occ = 0;
  bit          acc_prev = 0;
  bit          ret_prev = 0;
  bit          mon_en = 0;
  logic [15:0] exp_pipe = '0;
  logic [2:0]  exp_stat = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: account for the edge just taken, then drive the next inputs.
  task automatic step(input logic v, input logic [15:0] d, input logic [2:0] a,
                      input logic o, input logic r, input logic rst);
    ent_t e;
    @(posedge clk);
    #1;
    if (reset) begin
      occ = 0;
      exp_q.delete();
      exp_pipe = '0;
      exp_stat = '0;
      check("reset_waddr", 32'(rf_waddr), 32'd0);
      check("reset_wdata", 32'(rf_wdata), 32'd0);
      check("reset_pipe", 32'(pipeline_out), 32'd0);
      check("reset_status", 32'(status), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
    end else begin
      occ = occ + (acc_prev ? 1 : 0) - (ret_prev ? 1 : 0);
    end
    acc_prev = v && (occ < 2) && !rst;
    ret_prev = r && (occ > 0) && !rst;
    reset    = rst;
    in_valid = v;
    in_data  = d;
    in_dst   = a;
    in_ovf   = o;
    rf_ready = r;
    if (acc_prev) begin
      e.data = d;
      e.dst  = a;
      e.ovf  = o;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      check("in_ready", 32'(in_ready), (occ < 2) ? 32'd1 : 32'd0);
      check("busy", 32'(busy), (occ != 0) ? 32'd1 : 32'd0);
      check("rf_we", 32'(rf_we), (occ != 0) ? 32'd1 : 32'd0);
      check("pipeline_out", 32'(pipeline_out), 32'(exp_pipe));
      check("status", 32'(status), 32'(exp_stat));
      if (occ != 0) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          check("rf_waddr", 32'(rf_waddr), 32'(exp_q[0].dst));
          check("rf_wdata", 32'(rf_wdata), 32'(exp_q[0].data));
          if (rf_ready && !reset) begin
            e = exp_q.pop_front();
            exp_pipe = e.data;
            exp_stat = {(e.data == 16'h0000), e.data[15], e.ovf};
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dst   = '0;
    in_ovf   = 1'b0;
    rf_ready = 1'b0;
    repeat (2) @(posedge clk);
    step(0, 16'h0, 3'd0, 0, 0, 0);
    mon_en = 1;

    // Idle after reset
    repeat (10) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Single write
    step(1, 16'h8000, 3'd5, 0, 1, 0);
    repeat (3) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Streaming
    for (int i = 1; i <= 4; i++) step(1, 16'(i), 3'(i), 0, 1, 0);
    repeat (3) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Backpressure: third push must be ignored
    step(1, 16'h0000, 3'd1, 1, 0, 0);
    step(1, 16'h0007, 3'd2, 0, 0, 0);
    step(1, 16'h1234, 3'd3, 1, 0, 0);
    repeat (3) step(0, 16'h0, 3'd0, 0, 0, 0);
    repeat (4) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Reset with two entries buffered
    step(1, 16'hAAAA, 3'd6, 1, 0, 0);
    step(1, 16'h5555, 3'd7, 0, 0, 0);
    step(0, 16'h0, 3'd0, 0, 0, 1);
    step(0, 16'h0, 3'd0, 0, 1, 0);
    repeat (3) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Simultaneous accept and retire in ONE, destination 0
    step(1, 16'h00A1, 3'd0, 0, 0, 0);
    step(1, 16'h00B2, 3'd0, 1, 1, 0);
    repeat (3) step(0, 16'h0, 3'd0, 0, 1, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(0, 16'h0, 3'd0, 0, 0, 1);
      end else begin
        step($urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
             3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 2) != 0,
             0);
      end
    end

    repeat (6) step(0, 16'h0, 3'd0, 0, 1, 0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
